// File: rtl/output_fifo_8to16.sv
// Byte-to-word upconverting output FIFO: packs byte pairs into 16-bit words
// held in a small circular buffer and presents the head word first-word-fall-through.
module output_fifo_8to16 #(
  parameter int unsigned DEPTH_LOG2        = 5,
  parameter int unsigned PROG_EMPTY_THRESH = 4,
  parameter logic [7:0]  PAD_BYTE          = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            din,
  input  logic                  wr_en,
  output logic                  full,
  input  logic                  flush,
  output logic [15:0]           dout,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  prog_empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_PE   = (DEPTH_LOG2 + 1)'(PROG_EMPTY_THRESH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [15:0] mem [DEPTH];

  logic [7:0]            hold_byte_q, hold_byte_d;
  logic                  hold_valid_q, hold_valid_d;
  logic                  flush_pend_q, flush_pend_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;

  logic        ram_full;
  logic        wr_acc;
  logic        rd_acc;
  logic        mem_we;
  logic [15:0] mem_wdata;

  // A pending flush keeps full asserted until the padded word is committed.
  assign ram_full   = (count_q == CNT_FULL);
  assign full       = hold_valid_q & (ram_full | flush_pend_q);
  assign empty      = (count_q == '0);
  assign prog_empty = (count_q <= CNT_PE);
  assign count      = count_q;
  assign dout       = empty ? '0 : mem[rd_ptr_q];

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    hold_byte_d  = hold_byte_q;
    hold_valid_d = hold_valid_q;
    flush_pend_d = flush_pend_q;
    mem_we       = 1'b0;
    mem_wdata    = '0;

    if (flush_pend_q && !ram_full) begin
      mem_we       = 1'b1;
      mem_wdata    = {hold_byte_q, PAD_BYTE};
      hold_valid_d = 1'b0;
      flush_pend_d = 1'b0;
    end else if (wr_acc) begin
      if (hold_valid_q) begin
        mem_we       = 1'b1;
        mem_wdata    = {hold_byte_q, din};
        hold_valid_d = 1'b0;
      end else if (flush && !ram_full) begin
        mem_we    = 1'b1;
        mem_wdata = {din, PAD_BYTE};
      end else begin
        // A flushed byte arriving with the RAM full is parked and padded later.
        hold_byte_d  = din;
        hold_valid_d = 1'b1;
        flush_pend_d = flush;
      end
    end else if (flush && hold_valid_q) begin
      if (ram_full) begin
        flush_pend_d = 1'b1;
      end else begin
        mem_we       = 1'b1;
        mem_wdata    = {hold_byte_q, PAD_BYTE};
        hold_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    wr_ptr_d = mem_we ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (mem_we && !rd_acc) begin
      count_d = count_q + CNT_ONE;
    end else if (!mem_we && rd_acc) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_byte_q  <= '0;
      hold_valid_q <= 1'b0;
      flush_pend_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      hold_byte_q  <= hold_byte_d;
      hold_valid_q <= hold_valid_d;
      flush_pend_q <= flush_pend_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_output_fifo_8to16.sv
// Randomized and directed bench for output_fifo_8to16 against a queue-based
// model of the byte-pairing buffer.
module tb_output_fifo_8to16;

  localparam int unsigned DLOG  = 5;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned PE_TH = 4;
  localparam logic [7:0]  PAD   = 8'h00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = '0;
  logic        wr_en = 1'b0;
  logic        full;
  logic        flush = 1'b0;
  logic [15:0] dout;
  logic        rd_en = 1'b0;
  logic        empty;
  logic        prog_empty;
  logic [DLOG:0] count;

  int unsigned checks = 0;
  int unsigned failures = 0;

  // Reference model: stored words as a queue, plus the pending odd byte.
  logic [15:0] mq[$];
  logic [7:0]  m_hb;
  logic        m_hv;
  logic        m_fp;

  output_fifo_8to16 #(
    .DEPTH_LOG2(DLOG),
    .PROG_EMPTY_THRESH(PE_TH),
    .PAD_BYTE(PAD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .wr_en(wr_en),
    .full(full),
    .flush(flush),
    .dout(dout),
    .rd_en(rd_en),
    .empty(empty),
    .prog_empty(prog_empty),
    .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_hb = '0;
    m_hv = 1'b0;
    m_fp = 1'b0;
  endtask

  function automatic logic model_full();
    return m_hv && (mq.size() == DEPTH || m_fp);
  endfunction

  task automatic check_model();
    int unsigned n;
    n = mq.size();
    chk("full", 32'(full), 32'(model_full()));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("count", 32'(count), n);
    chk("prog_empty", 32'(prog_empty), 32'(n <= PE_TH));
    chk("dout", 32'(dout), (n == 0) ? 32'h0 : 32'(mq[0]));
  endtask

  // One clock of the reference behaviour, seen at the edge.
  task automatic model_edge(input logic w, input logic [7:0] d, input logic f, input logic r);
    int unsigned n;
    logic wacc;
    logic racc;
    n    = mq.size();
    wacc = w && !model_full();
    racc = r && (n != 0);
    if (racc) void'(mq.pop_front());
    if (m_fp && n < DEPTH) begin
      mq.push_back({m_hb, PAD});
      m_hv = 1'b0;
      m_fp = 1'b0;
    end else if (wacc) begin
      if (m_hv) begin
        mq.push_back({m_hb, d});
        m_hv = 1'b0;
      end else if (f && n < DEPTH) begin
        mq.push_back({d, PAD});
      end else begin
        m_hb = d;
        m_hv = 1'b1;
        m_fp = f;
      end
    end else if (f && m_hv && !m_fp) begin
      if (n < DEPTH) begin
        mq.push_back({m_hb, PAD});
        m_hv = 1'b0;
      end else begin
        m_fp = 1'b1;
      end
    end
  endtask

  // Called at posedge+1; leaves at posedge+1 of the following cycle.
  task automatic step(input logic w, input logic [7:0] d, input logic f, input logic r);
    wr_en = w;
    din   = d;
    flush = f;
    rd_en = r;
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_edge(w, d, f, r);
    #1;
    wr_en = 1'b0;
    flush = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_prog_empty", 32'(prog_empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_dout", 32'(dout), 32'h0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] b;
    int unsigned wp, rp, fp;
    model_clear();
    #1;
    do_reset();

    // Pair packing with FWFT latency
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    chk("pair_empty_after_1st", 32'(empty), 32'h1);
    step(1'b1, 8'hB2, 1'b0, 1'b0);
    chk("pair_empty_after_2nd", 32'(empty), 32'h0);
    chk("pair_dout", 32'(dout), 32'hA1B2);
    chk("pair_count", 32'(count), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("pair_empty_after_pop", 32'(empty), 32'h1);

    // Flush padding of an odd byte and write+flush with empty hold
    step(1'b1, 8'h5C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_dout", 32'(dout), 32'h5C00);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("wrflush_count", 32'(count), 32'h2);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("wrflush_dout", 32'(dout), 32'h7700);
    step(1'b1, 8'h33, 1'b0, 1'b0);

    // Reset mid-stream with a word stored and a byte held
    do_reset();

    // Fill to full, reject extra byte, pop, complete tail, drain across wrap
    for (int i = 0; i < 65; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_count", 32'(count), 32'd32);
    chk("fill_full", 32'(full), 32'h1);
    step(1'b1, 8'h99, 1'b0, 1'b0);
    chk("fill_ignored_count", 32'(count), 32'd32);
    chk("fill_head", 32'(dout), 32'h0001);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("fill_full_after_pop", 32'(full), 32'h0);
    step(1'b1, 8'h41, 1'b0, 1'b0);
    for (int i = 0; i < 31; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("fill_tail_word", 32'(dout), 32'h4041);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("fill_drained", 32'(empty), 32'h1);

    // Flush while RAM full is deferred until a slot frees
    do_reset();
    for (int i = 0; i < 64; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pend_full", 32'(full), 32'h1);
    chk("pend_count", 32'(count), 32'd32);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("pend_full_until_commit", 32'(full), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("pend_commit_count", 32'(count), 32'd32);
    chk("pend_commit_full", 32'(full), 32'h0);
    for (int i = 0; i < 31; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("pend_tail_word", 32'(dout), 32'hEE00);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Simultaneous write+read keeps count; prog_empty threshold edges
    do_reset();
    for (int i = 0; i < 11; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    step(1'b1, 8'h20, 1'b0, 1'b1);
    chk("wr_rd_count", 32'(count), 32'd5);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("pe_count4", 32'(count), 32'd4);
    chk("pe_at_thresh", 32'(prog_empty), 32'h1);
    step(1'b1, 8'h21, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    chk("pe_count5", 32'(count), 32'd5);
    chk("pe_above_thresh", 32'(prog_empty), 32'h0);

    // Randomized traffic with shifting write/read/flush bias
    do_reset();
    for (int unsigned ph = 0; ph < 16; ph++) begin
      wp = $urandom_range(10, 95);
      rp = $urandom_range(10, 95);
      fp = $urandom_range(0, 20);
      for (int unsigned c = 0; c < 200; c++) begin
        b = 8'($urandom);
        step(($urandom_range(0, 99) < wp), b, ($urandom_range(0, 99) < fp),
             ($urandom_range(0, 99) < rp));
      end
      if (ph == 8) do_reset();
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
